// File: rtl/spi_stream_pkg.sv
// spi_stream_pkg
//   Shared types and constants for the SPI counter-stream source:
//   - state_e                : stream FSM states
//   - SYNC_PATTERN_ALL_ONES  : frame sync word (sliced to WIDTH by the user)
//   - EDGE_FALL / EDGE_RISE  : {older, newer} sample patterns of a 2-flop synchroniser
//   - sat_inc16()            : saturating 16-bit increment for the word counter
package spi_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam logic [31:0] SYNC_PATTERN_ALL_ONES = 32'hFFFF_FFFF;

  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_RISE = 2'b01;

  // Word counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect
//   Two-flop synchroniser for an asynchronous SPI pin with registered
//   single-cycle rise/fall pulses. The pulses appear one clk after the edge
//   pattern is present in the synchroniser, so they line up with level_o.
// Ports
//   clk     in  system clock
//   reset   in  synchronous, active-high; loads RESET_VAL into the synchroniser
//   din_i   in  asynchronous input pin
//   level_o out synchronised level (older synchroniser stage)
//   rise_o  out one-clk pulse after a 0->1 transition
//   fall_o  out one-clk pulse after a 1->0 transition
module spi_edge_detect
  import spi_stream_pkg::*;
#(
  parameter logic [1:0] RESET_VAL = 2'b00
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // sync_q[1] is the older sample, sync_q[0] the newer one.
  logic [1:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  // Synchroniser and registered edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din_i};
      rise_q <= (sync_q == EDGE_RISE);
      fall_q <= (sync_q == EDGE_FALL);
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_counter_stream.sv
// spi_counter_stream
//   SPI-slave (mode 0) test-pattern source. While SSEL is low it shifts an
//   all-ones sync word followed by an incrementing WIDTH-bit counter onto
//   MISO, changing bits after SCK falling edges. GAP_BITS high-Z bit slots
//   follow every word.
// Parameters
//   WIDTH (2..32), GAP_BITS (0..15), START, STEP, MSB_FIRST
// Ports
//   clk        in    system clock
//   reset      in    synchronous, active-high
//   SSEL       in    chip select, active low, asynchronous
//   SCK        in    SPI clock, asynchronous, idles low
//   MOSI       in    master data, only used when SPI_CNT_RX_EN is defined
//   MISO       inout driven in SYNC/DATA, high-Z otherwise
//   word_count out   words completed in this frame incl. sync word, saturating
//   busy       out   FSM not idle
// Configuration
//   SPI_CNT_RX_EN : when defined, the first WIDTH bits received on MOSI in a
//                   frame replace the counter value.
module spi_counter_stream
  import spi_stream_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned GAP_BITS  = 1,
  parameter int unsigned START     = 0,
  parameter int unsigned STEP      = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SSEL,
  input  logic        SCK,
  input  logic        MOSI,
  inout  wire         MISO,
  output logic [15:0] word_count,
  output logic        busy
);

  localparam logic [WIDTH-1:0] START_W  = WIDTH'(START);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] SYNC_W   = SYNC_PATTERN_ALL_ONES[WIDTH-1:0];
  localparam logic [5:0]       BIT_LAST = 6'(WIDTH - 1);
  localparam logic [4:0]       GAP_LAST = (GAP_BITS > 0) ? 5'(GAP_BITS - 1) : 5'd0;

  // Synchronised pins.
  logic ssel_level_s, ssel_rise_s, ssel_fall_s;
  logic sck_level_s, sck_rise_s, sck_fall_s;

  spi_edge_detect #(.RESET_VAL(2'b11)) u_ssel_sync (
    .clk     (clk),
    .reset   (reset),
    .din_i   (SSEL),
    .level_o (ssel_level_s),
    .rise_o  (ssel_rise_s),
    .fall_o  (ssel_fall_s)
  );

  spi_edge_detect #(.RESET_VAL(2'b00)) u_sck_sync (
    .clk     (clk),
    .reset   (reset),
    .din_i   (SCK),
    .level_o (sck_level_s),
    .rise_o  (sck_rise_s),
    .fall_o  (sck_fall_s)
  );

  // Receive-path interface into the main FSM.
  logic             rx_load_s;
  logic [WIDTH-1:0] rx_word_s;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [5:0]       bit_idx_q, bit_idx_d;
  logic [4:0]       gap_idx_q, gap_idx_d;
  logic [15:0]      word_count_q, word_count_d;
  logic             tx_bit_q;
  logic             drive_q;
  logic             busy_q;
  logic [WIDTH-1:0] rotated_s;

`ifdef SPI_CNT_RX_EN
  logic             mosi_level_s;
  logic             mosi_rise_unused_s, mosi_fall_unused_s;
  logic [WIDTH-1:0] rx_shreg_q, rx_shreg_d;
  logic [5:0]       rx_cnt_q, rx_cnt_d;
  logic             rx_done_q, rx_done_d;
  logic [WIDTH-1:0] rx_shifted_s;
  logic             unused_s;

  spi_edge_detect #(.RESET_VAL(2'b00)) u_mosi_sync (
    .clk     (clk),
    .reset   (reset),
    .din_i   (MOSI),
    .level_o (mosi_level_s),
    .rise_o  (mosi_rise_unused_s),
    .fall_o  (mosi_fall_unused_s)
  );

  assign unused_s = ^{ssel_rise_s, sck_level_s, mosi_rise_unused_s, mosi_fall_unused_s};

  // Receive shifter: only the first WIDTH rising edges of a frame are captured.
  always_comb begin
    rx_shreg_d = rx_shreg_q;
    rx_cnt_d   = rx_cnt_q;
    rx_done_d  = rx_done_q;
    rx_load_s  = 1'b0;
    if (MSB_FIRST) begin
      rx_shifted_s = {rx_shreg_q[WIDTH-2:0], mosi_level_s};
    end else begin
      rx_shifted_s = {mosi_level_s, rx_shreg_q[WIDTH-1:1]};
    end
    rx_word_s = rx_shifted_s;
    if (ssel_fall_s) begin
      rx_cnt_d  = 6'd0;
      rx_done_d = 1'b0;
    end else if (sck_rise_s && !ssel_level_s && (state_q != IDLE) && !rx_done_q) begin
      rx_shreg_d = rx_shifted_s;
      if (rx_cnt_q == BIT_LAST) begin
        rx_done_d = 1'b1;
        rx_load_s = 1'b1;
      end else begin
        rx_cnt_d = rx_cnt_q + 6'd1;
      end
    end else begin
      rx_cnt_d = rx_cnt_q;
    end
  end

  // Receive shifter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shreg_q <= {WIDTH{1'b0}};
      rx_cnt_q   <= 6'd0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_shreg_q <= rx_shreg_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_done_q  <= rx_done_d;
    end
  end
`else
  logic unused_s;

  assign unused_s  = ^{ssel_rise_s, sck_level_s, sck_rise_s, MOSI};
  assign rx_load_s = 1'b0;
  assign rx_word_s = {WIDTH{1'b0}};
`endif

  // Rotate the shift register one place toward the transmit head bit.
  always_comb begin
    if (MSB_FIRST) begin
      rotated_s = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
    end else begin
      rotated_s = {shreg_q[0], shreg_q[WIDTH-1:1]};
    end
  end

  // Stream FSM next-state logic. SSEL high dominates, then an SSEL falling
  // edge, so an SCK edge in the same clk as either is ignored.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    counter_d    = counter_q;
    bit_idx_d    = bit_idx_q;
    gap_idx_d    = gap_idx_q;
    word_count_d = word_count_q;

    if (ssel_level_s) begin
      state_d = IDLE;
    end else if (ssel_fall_s) begin
      state_d      = SYNC;
      shreg_d      = SYNC_W;
      bit_idx_d    = 6'd0;
      counter_d    = START_W;
      word_count_d = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SYNC, DATA: begin
          if (sck_fall_s) begin
            shreg_d = rotated_s;
            if (bit_idx_q == BIT_LAST) begin
              word_count_d = sat_inc16(word_count_q);
              if (GAP_BITS > 0) begin
                state_d   = GAP;
                gap_idx_d = 5'd0;
              end else begin
                state_d   = DATA;
                shreg_d   = counter_q;
                counter_d = counter_q + STEP_W;
                bit_idx_d = 6'd0;
              end
            end else begin
              bit_idx_d = bit_idx_q + 6'd1;
            end
          end else begin
            state_d = state_q;
          end
        end
        GAP: begin
          if (sck_fall_s) begin
            if (gap_idx_q == GAP_LAST) begin
              state_d   = DATA;
              shreg_d   = counter_q;
              counter_d = counter_q + STEP_W;
              bit_idx_d = 6'd0;
            end else begin
              gap_idx_d = gap_idx_q + 5'd1;
            end
          end else begin
            state_d = GAP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // A completed receive word becomes the next value to transmit.
    if (rx_load_s) begin
      counter_d = rx_word_s;
    end else begin
      counter_d = counter_d;
    end
  end

  // State and output registers; MISO bit and enable are derived from the
  // next-state values so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= SYNC_W;
      counter_q    <= START_W;
      bit_idx_q    <= 6'd0;
      gap_idx_q    <= 5'd0;
      word_count_q <= 16'd0;
      tx_bit_q     <= 1'b0;
      drive_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      counter_q    <= counter_d;
      bit_idx_q    <= bit_idx_d;
      gap_idx_q    <= gap_idx_d;
      word_count_q <= word_count_d;
      tx_bit_q     <= MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
      drive_q      <= (state_d == SYNC) || (state_d == DATA);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign MISO       = drive_q ? tx_bit_q : 1'bz;
  assign word_count = word_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_counter_stream.sv
// Self-checking bench for spi_counter_stream. Each DUT configuration is
// instantiated twice, once on a pulled-up and once on a pulled-down MISO
// net, so a released (high-Z) MISO can be told apart from a driven level.
module tb_spi_counter_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sck, mosi, ssel_a, ssel_b;
  wire  miso_a_pu, miso_a_pd, miso_b_pu, miso_b_pd;
  logic [15:0] wc_a_pu, wc_a_pd, wc_b_pu, wc_b_pd;
  logic busy_a_pu, busy_a_pd, busy_b_pu, busy_b_pd;

  pullup   (miso_a_pu);
  pulldown (miso_a_pd);
  pullup   (miso_b_pu);
  pulldown (miso_b_pd);

  // Configuration A: WIDTH=4, GAP_BITS=1, START=0, STEP=1, MSB first.
  spi_counter_stream #(.WIDTH(4), .GAP_BITS(1), .START(0), .STEP(1), .MSB_FIRST(1'b1)) u_a_pu (
    .clk(clk), .reset(reset), .SSEL(ssel_a), .SCK(sck), .MOSI(mosi),
    .MISO(miso_a_pu), .word_count(wc_a_pu), .busy(busy_a_pu));
  spi_counter_stream #(.WIDTH(4), .GAP_BITS(1), .START(0), .STEP(1), .MSB_FIRST(1'b1)) u_a_pd (
    .clk(clk), .reset(reset), .SSEL(ssel_a), .SCK(sck), .MOSI(mosi),
    .MISO(miso_a_pd), .word_count(wc_a_pd), .busy(busy_a_pd));

  // Configuration B: WIDTH=4, GAP_BITS=0, START=1, STEP=1, LSB first.
  spi_counter_stream #(.WIDTH(4), .GAP_BITS(0), .START(1), .STEP(1), .MSB_FIRST(1'b0)) u_b_pu (
    .clk(clk), .reset(reset), .SSEL(ssel_b), .SCK(sck), .MOSI(mosi),
    .MISO(miso_b_pu), .word_count(wc_b_pu), .busy(busy_b_pu));
  spi_counter_stream #(.WIDTH(4), .GAP_BITS(0), .START(1), .STEP(1), .MSB_FIRST(1'b0)) u_b_pd (
    .clk(clk), .reset(reset), .SSEL(ssel_b), .SCK(sck), .MOSI(mosi),
    .MISO(miso_b_pd), .word_count(wc_b_pd), .busy(busy_b_pd));

  int checks = 0;
  int errors = 0;

  // MISO codes: 0 / 1 = driven level, 2 = high-Z, 3 = inconsistent.
  localparam logic [1:0] C0 = 2'd0;
  localparam logic [1:0] C1 = 2'd1;
  localparam logic [1:0] CZ = 2'd2;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  function automatic logic [1:0] miso_code(input logic pu, input logic pd);
    if (pu == pd) return {1'b0, pu};
    else if (pu && !pd) return CZ;
    else return 2'd3;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_status(input string name, input bit on_b, input int exp_wc,
                              input int exp_busy, input logic [1:0] exp_miso);
    if (on_b) begin
      chk({name, "_wc"}, int'(wc_b_pu), exp_wc);
      chk({name, "_wc_pd"}, int'(wc_b_pd), exp_wc);
      chk({name, "_busy"}, int'(busy_b_pu), exp_busy);
      chk({name, "_busy_pd"}, int'(busy_b_pd), exp_busy);
      chk({name, "_miso"}, int'(miso_code(miso_b_pu, miso_b_pd)), int'(exp_miso));
    end else begin
      chk({name, "_wc"}, int'(wc_a_pu), exp_wc);
      chk({name, "_wc_pd"}, int'(wc_a_pd), exp_wc);
      chk({name, "_busy"}, int'(busy_a_pu), exp_busy);
      chk({name, "_busy_pd"}, int'(busy_a_pd), exp_busy);
      chk({name, "_miso"}, int'(miso_code(miso_a_pu, miso_a_pd)), int'(exp_miso));
    end
  endtask

  // Expected transmit bits for one 4-bit word in shift order.
  task automatic push_word(input bit on_b, input logic [3:0] v, input bit msb);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] c;
      c = {1'b0, (msb ? v[3-i] : v[i])};
      if (on_b) q_b.push_back(c);
      else q_a.push_back(c);
    end
  endtask

  task automatic push_z(input bit on_b);
    if (on_b) q_b.push_back(CZ);
    else q_a.push_back(CZ);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period: 8 clk high then 8 clk low.
  task automatic run_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1;
      wait_clk(8);
      sck = 1'b0;
      wait_clk(8);
    end
  endtask

  task automatic run_bits_mosi(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      mosi = v[3-i];
      wait_clk(4);
      run_bits(1);
    end
    mosi = 1'b0;
  endtask

  // Monitors: a master samples MISO on every SCK rising edge of a selected slave.
  always @(posedge sck) begin
    if (!ssel_a) begin
      logic [1:0] got_a, exp_a;
      got_a = miso_code(miso_a_pu, miso_a_pd);
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL stream_a underflow got %0d", got_a);
      end else begin
        exp_a = q_a.pop_front();
        if (got_a != exp_a) begin
          errors++;
          $display("FAIL stream_a bit got %0d expected %0d", got_a, exp_a);
        end
      end
    end
  end

  always @(posedge sck) begin
    if (!ssel_b) begin
      logic [1:0] got_b, exp_b;
      got_b = miso_code(miso_b_pu, miso_b_pd);
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL stream_b underflow got %0d", got_b);
      end else begin
        exp_b = q_b.pop_front();
        if (got_b != exp_b) begin
          errors++;
          $display("FAIL stream_b bit got %0d expected %0d", got_b, exp_b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    sck    = 1'b0;
    mosi   = 1'b0;
    ssel_a = 1'b1;
    ssel_b = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    check_status("reset_a", 1'b0, 0, 0, CZ);
    check_status("reset_b", 1'b1, 0, 0, CZ);

    // 1: sync word, gap, 0000, gap, 0001, gap -> 15 bit slots, 3 words.
    ssel_a = 1'b0;
    wait_clk(8);
    check_status("t1_start", 1'b0, 0, 1, C1);
    push_word(1'b0, 4'b1111, 1'b1); push_z(1'b0);
    push_word(1'b0, 4'b0000, 1'b1); push_z(1'b0);
    push_word(1'b0, 4'b0001, 1'b1); push_z(1'b0);
    run_bits(15);
    chk("t1_wc", int'(wc_a_pu), 3);

    // 2: 18 words incl. sync; data counts 0..15 then wraps to 0.
    ssel_a = 1'b1;
    wait_clk(8);
    check_status("t2_idle", 1'b0, 3, 0, CZ);
    ssel_a = 1'b0;
    wait_clk(8);
    chk("t2_wc_clear", int'(wc_a_pu), 0);
    push_word(1'b0, 4'b1111, 1'b1); push_z(1'b0);
    for (int i = 0; i < 17; i++) begin
      push_word(1'b0, 4'(i), 1'b1);
      push_z(1'b0);
    end
    run_bits(90);
    chk("t2_wc", int'(wc_a_pu), 18);

    // 4: abort after 2 bits of the third word, then restart the frame.
    ssel_a = 1'b1;
    wait_clk(8);
    ssel_a = 1'b0;
    wait_clk(8);
    push_word(1'b0, 4'b1111, 1'b1); push_z(1'b0);
    push_word(1'b0, 4'b0000, 1'b1); push_z(1'b0);
    q_a.push_back(C0); q_a.push_back(C0);
    run_bits(12);
    ssel_a = 1'b1;
    wait_clk(8);
    check_status("t4_abort", 1'b0, 2, 0, CZ);
    ssel_a = 1'b0;
    wait_clk(8);
    check_status("t4_restart", 1'b0, 0, 1, C1);
    push_word(1'b0, 4'b1111, 1'b1); push_z(1'b0);
    push_word(1'b0, 4'b0000, 1'b1); push_z(1'b0);
    run_bits(10);
    chk("t4_wc", int'(wc_a_pu), 2);

    // 5: reset in the middle of a data word.
    ssel_a = 1'b1;
    wait_clk(8);
    ssel_a = 1'b0;
    wait_clk(8);
    push_word(1'b0, 4'b1111, 1'b1); push_z(1'b0);
    q_a.push_back(C0); q_a.push_back(C0);
    run_bits(7);
    reset  = 1'b1;
    ssel_a = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_status("t5_reset", 1'b0, 0, 0, CZ);
    run_bits(3);
    check_status("t5_ignored", 1'b0, 0, 0, CZ);
    ssel_a = 1'b0;
    wait_clk(8);
    push_word(1'b0, 4'b1111, 1'b1); push_z(1'b0);
    push_word(1'b0, 4'b0000, 1'b1);
    run_bits(9);
    chk("t5_wc", int'(wc_a_pu), 2);
    ssel_a = 1'b1;
    wait_clk(8);

    // 3: LSB first, START=1, no gap slots.
    ssel_b = 1'b0;
    wait_clk(8);
    push_word(1'b1, 4'b1111, 1'b0);
    push_word(1'b1, 4'b0001, 1'b0);
    push_word(1'b1, 4'b0010, 1'b0);
    push_word(1'b1, 4'b0011, 1'b0);
    run_bits(16);
    check_status("t3_end", 1'b1, 4, 1, C0);
    ssel_b = 1'b1;
    wait_clk(8);

`ifdef SPI_CNT_RX_EN
    // 6: word received during the sync word seeds the counter.
    ssel_a = 1'b0;
    wait_clk(8);
    push_word(1'b0, 4'b1111, 1'b1); push_z(1'b0);
    push_word(1'b0, 4'b1010, 1'b1); push_z(1'b0);
    push_word(1'b0, 4'b1011, 1'b1);
    run_bits_mosi(4'b1010);
    run_bits(10);
    chk("t6_wc", int'(wc_a_pu), 3);
    ssel_a = 1'b1;
    wait_clk(8);
`endif

    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
